// File: rtl/axi_lite_xbar_if.sv
// AXI-Lite channel bundle shared by the crossbar upstream and downstream ports.
// Master drives address/data/valid and response-ready; slave drives the rest.
interface axi_lite_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb,
    output wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb,
    input  wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_xbar.sv
// 1-to-2 AXI-Lite crossbar (CLINT / memory) with independent read and write FSMs.
// Define XBAR_DECERR_EN to answer addresses outside both windows locally with DECERR.
module axi_lite_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0a000000,
  parameter logic [31:0] CLINT_SIZE = 32'h00010000,
  parameter logic [31:0] MEM_BASE   = 32'h80000000,
  parameter logic [31:0] MEM_SIZE   = 32'h08000000
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  s,
  axi_lite_if.master m_clint,
  axi_lite_if.master m_mem
);

  typedef enum logic [1:0] {T_MEM, T_CLINT, T_ERR} tgt_e;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_ERR} rd_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP, WR_ERR} wr_e;

  localparam logic [32:0] CLINT_END =
    {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
  localparam logic [32:0] MEM_END =
    {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
`ifdef XBAR_DECERR_EN
  localparam tgt_e MISS = T_ERR;
`else
  localparam tgt_e MISS = T_MEM;
`endif

  function automatic tgt_e decode(input logic [31:0] a);
    logic in_c;
    logic in_m;
    in_c = ({1'b0, a} >= {1'b0, CLINT_BASE})
        && ({1'b0, a} < CLINT_END);
    in_m = ({1'b0, a} >= {1'b0, MEM_BASE})
        && ({1'b0, a} < MEM_END);
    unique case (1'b1)
      in_c:    decode = T_CLINT;
      in_m:    decode = T_MEM;
      default: decode = MISS;
    endcase
  endfunction

  rd_e  rd_q, rd_d;
  wr_e  wr_q, wr_d;
  tgt_e rd_sel_q, rd_sel_d;
  tgt_e wr_sel_q, wr_sel_d;
  tgt_e ar_tgt, aw_tgt;
  logic wdone_q, wdone_d;
  logic blk_q, blk;
  logic ar_rdy, r_vld;
  logic aw_rdy, w_rdy, b_vld;

  assign ar_tgt = decode(s.araddr);
  assign aw_tgt = decode(s.awaddr);
  // hold every valid low during reset and the cycle after it
  assign blk    = reset | blk_q;

  always_ff @(posedge clk) begin
    blk_q <= reset;
    if (reset) begin
      rd_q     <= RD_IDLE;
      rd_sel_q <= T_MEM;
      wr_q     <= WR_IDLE;
      wr_sel_q <= T_MEM;
      wdone_q  <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rd_sel_q <= rd_sel_d;
      wr_q     <= wr_d;
      wr_sel_q <= wr_sel_d;
      wdone_q  <= wdone_d;
    end
  end

  always_comb begin
    rd_d     = rd_q;
    rd_sel_d = rd_sel_q;
    unique case (rd_q)
      RD_IDLE: begin
        if (s.arvalid && ar_rdy) begin
          rd_sel_d = ar_tgt;
          rd_d = (ar_tgt == T_ERR) ? RD_ERR : RD_WAIT;
        end
      end
      RD_WAIT, RD_ERR: begin
        if (r_vld && s.rready) rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  always_comb begin
    m_clint.araddr  = s.araddr;
    m_mem.araddr    = s.araddr;
    m_clint.arvalid = 1'b0;
    m_mem.arvalid   = 1'b0;
    m_clint.rready  = 1'b0;
    m_mem.rready    = 1'b0;
    ar_rdy  = 1'b0;
    r_vld   = 1'b0;
    s.rdata = '0;
    s.rresp = 2'b00;
    unique case (rd_q)
      RD_IDLE: begin
        if (!blk) begin
          unique case (ar_tgt)
            T_CLINT: begin
              m_clint.arvalid = s.arvalid;
              ar_rdy = m_clint.arready;
            end
            T_MEM: begin
              m_mem.arvalid = s.arvalid;
              ar_rdy = m_mem.arready;
            end
            default: ar_rdy = 1'b1;
          endcase
        end
      end
      RD_WAIT: begin
        if (rd_sel_q == T_CLINT) begin
          r_vld   = m_clint.rvalid;
          s.rdata = m_clint.rdata;
          s.rresp = m_clint.rresp;
          m_clint.rready = s.rready;
        end else begin
          r_vld   = m_mem.rvalid;
          s.rdata = m_mem.rdata;
          s.rresp = m_mem.rresp;
          m_mem.rready = s.rready;
        end
      end
      RD_ERR: begin
        r_vld   = 1'b1;
        s.rresp = 2'b11;
      end
      default: ;
    endcase
    s.arready = ar_rdy;
    s.rvalid  = r_vld & ~blk;
  end

  always_comb begin
    wr_d     = wr_q;
    wr_sel_d = wr_sel_q;
    wdone_d  = wdone_q;
    unique case (wr_q)
      WR_IDLE: begin
        if (s.awvalid && aw_rdy) begin
          wr_sel_d = aw_tgt;
          wdone_d  = 1'b0;
          if ((s.wvalid && w_rdy) || wdone_q)
            wr_d = (aw_tgt == T_ERR) ? WR_ERR : WR_RESP;
          else
            wr_d = WR_DATA;
        end else if (s.wvalid && w_rdy) begin
          // target took W before AW; remember it
          wdone_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (s.wvalid && w_rdy)
          wr_d = (wr_sel_q == T_ERR) ? WR_ERR : WR_RESP;
      end
      WR_RESP, WR_ERR: begin
        if (b_vld && s.bready) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  always_comb begin
    m_clint.awaddr  = s.awaddr;
    m_mem.awaddr    = s.awaddr;
    m_clint.wdata   = s.wdata;
    m_mem.wdata     = s.wdata;
    m_clint.wstrb   = s.wstrb;
    m_mem.wstrb     = s.wstrb;
    m_clint.awvalid = 1'b0;
    m_mem.awvalid   = 1'b0;
    m_clint.wvalid  = 1'b0;
    m_mem.wvalid    = 1'b0;
    m_clint.bready  = 1'b0;
    m_mem.bready    = 1'b0;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    b_vld   = 1'b0;
    s.bresp = 2'b00;
    unique case (wr_q)
      WR_IDLE: begin
        if (!blk) begin
          unique case (aw_tgt)
            T_CLINT: begin
              m_clint.awvalid = s.awvalid;
              m_clint.wvalid  =
                s.awvalid & s.wvalid & ~wdone_q;
              aw_rdy = m_clint.awready;
              w_rdy  =
                s.awvalid & ~wdone_q & m_clint.wready;
            end
            T_MEM: begin
              m_mem.awvalid = s.awvalid;
              m_mem.wvalid  =
                s.awvalid & s.wvalid & ~wdone_q;
              aw_rdy = m_mem.awready;
              w_rdy  =
                s.awvalid & ~wdone_q & m_mem.wready;
            end
            default: begin
              aw_rdy = 1'b1;
              w_rdy  = s.awvalid & ~wdone_q;
            end
          endcase
        end
      end
      WR_DATA: begin
        unique case (wr_sel_q)
          T_CLINT: begin
            m_clint.wvalid = s.wvalid;
            w_rdy = m_clint.wready;
          end
          T_MEM: begin
            m_mem.wvalid = s.wvalid;
            w_rdy = m_mem.wready;
          end
          default: w_rdy = 1'b1;
        endcase
      end
      WR_RESP: begin
        if (wr_sel_q == T_CLINT) begin
          b_vld   = m_clint.bvalid;
          s.bresp = m_clint.bresp;
          m_clint.bready = s.bready;
        end else begin
          b_vld   = m_mem.bvalid;
          s.bresp = m_mem.bresp;
          m_mem.bready = s.bready;
        end
      end
      WR_ERR: begin
        b_vld   = 1'b1;
        s.bresp = 2'b11;
      end
      default: ;
    endcase
    s.awready = aw_rdy;
    s.wready  = w_rdy;
    s.bvalid  = b_vld & ~blk;
  end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Scoreboard bench for axi_lite_xbar with behavioural CLINT and memory slaves.
// Expected responses are queued at issue time and popped by a negedge monitor.
module tb_axi_lite_xbar;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_lite_if s_if ();
  axi_lite_if c_if ();
  axi_lite_if m_if ();

  axi_lite_xbar dut (
    .clk     (clk),
    .reset   (reset),
    .s       (s_if),
    .m_clint (c_if),
    .m_mem   (m_if)
  );

`ifdef XBAR_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;
  // tgt: 0 mem, 1 clint; ch: 0 AR, 1 AW, 2 W
  typedef struct {
    int          tgt;
    int          ch;
    logic [31:0] val;
  } dn_t;

  rsp_t       r_q[$];
  logic [1:0] b_q[$];
  dn_t        dn_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void dn_ev(input int t, input int c,
                                input logic [31:0] v);
    int idx = -1;
    n_tests++;
    foreach (dn_q[i])
      if (idx < 0 && dn_q[i].tgt == t && dn_q[i].ch == c
          && dn_q[i].val == v) idx = i;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL downstream tgt=%0d ch=%0d: got %h expected no event",
               t, c, v);
    end else begin
      dn_q.delete(idx);
    end
  endfunction

  // ---------------- slave models ----------------
  logic [31:0] mem_st [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_st.exists(a) ? mem_st[a] : a;
  endfunction

  function automatic logic [31:0] clint_rd(input logic [31:0] a);
    logic [15:0] o;
    o = a[15:0];
    case (o)
      16'h0048: return 32'h3456789a;
      16'h004c: return 32'h00000012;
      default:  return 32'h0;
    endcase
  endfunction

  logic mw_aw, mw_w, cw_aw, cw_w;
  logic [31:0] mw_a, mw_d, cw_a, cw_d;

  assign m_if.arready = !m_if.rvalid;
  assign m_if.awready = !mw_aw && !m_if.bvalid;
  assign m_if.wready  = !mw_w && !m_if.bvalid;
  assign c_if.arready = !c_if.rvalid;
  assign c_if.awready = !cw_aw && !c_if.bvalid;
  assign c_if.wready  = !cw_w && !c_if.bvalid;

  always @(posedge clk) begin : mem_model
    logic ha, hw;
    logic [31:0] a, d;
    if (reset) begin
      m_if.rvalid <= 1'b0;
      m_if.bvalid <= 1'b0;
      mw_aw <= 1'b0;
      mw_w  <= 1'b0;
    end else begin
      if (m_if.arvalid && m_if.arready) begin
        m_if.rvalid <= 1'b1;
        m_if.rdata  <= mem_rd(m_if.araddr);
        m_if.rresp  <= 2'b00;
      end else if (m_if.rvalid && m_if.rready) begin
        m_if.rvalid <= 1'b0;
      end
      ha = mw_aw || (m_if.awvalid && m_if.awready);
      a  = mw_aw ? mw_a : m_if.awaddr;
      hw = mw_w || (m_if.wvalid && m_if.wready);
      d  = mw_w ? mw_d : m_if.wdata;
      if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
      if (ha && hw) begin
        mem_st[a] = d;
        m_if.bvalid <= 1'b1;
        m_if.bresp  <= 2'b00;
        mw_aw <= 1'b0;
        mw_w  <= 1'b0;
      end else begin
        if (ha) begin mw_aw <= 1'b1; mw_a <= a; end
        if (hw) begin mw_w <= 1'b1; mw_d <= d; end
      end
    end
  end

  // mtime (0x48/0x4c) is read-only here: writes get SLVERR
  always @(posedge clk) begin : clint_model
    logic ha, hw;
    logic [31:0] a;
    if (reset) begin
      c_if.rvalid <= 1'b0;
      c_if.bvalid <= 1'b0;
      cw_aw <= 1'b0;
      cw_w  <= 1'b0;
    end else begin
      if (c_if.arvalid && c_if.arready) begin
        c_if.rvalid <= 1'b1;
        c_if.rdata  <= clint_rd(c_if.araddr);
        c_if.rresp  <= 2'b00;
      end else if (c_if.rvalid && c_if.rready) begin
        c_if.rvalid <= 1'b0;
      end
      ha = cw_aw || (c_if.awvalid && c_if.awready);
      a  = cw_aw ? cw_a : c_if.awaddr;
      hw = cw_w || (c_if.wvalid && c_if.wready);
      if (c_if.bvalid && c_if.bready) c_if.bvalid <= 1'b0;
      if (ha && hw) begin
        c_if.bvalid <= 1'b1;
        c_if.bresp  <= (a[15:0] == 16'h0048 || a[15:0] == 16'h004c)
                       ? 2'b10 : 2'b00;
        cw_aw <= 1'b0;
        cw_w  <= 1'b0;
      end else begin
        if (ha) begin cw_aw <= 1'b1; cw_a <= a; end
        if (hw) begin cw_w <= 1'b1; cw_d <= c_if.wdata; end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (s_if.rvalid && s_if.rready) begin
        if (r_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got %h expected no response",
                   s_if.rdata);
        end else begin
          rsp_t e;
          e = r_q.pop_front();
          chk("rdata", s_if.rdata, e.data);
          chk("rresp", {30'd0, s_if.rresp}, {30'd0, e.resp});
        end
      end
      if (s_if.bvalid && s_if.bready) begin
        if (b_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got %b expected no response",
                   s_if.bresp);
        end else begin
          logic [1:0] eb;
          eb = b_q.pop_front();
          chk("bresp", {30'd0, s_if.bresp}, {30'd0, eb});
        end
      end
      if (c_if.arvalid && c_if.arready) dn_ev(1, 0, c_if.araddr);
      if (c_if.awvalid && c_if.awready) dn_ev(1, 1, c_if.awaddr);
      if (c_if.wvalid && c_if.wready)   dn_ev(1, 2, c_if.wdata);
      if (m_if.arvalid && m_if.arready) dn_ev(0, 0, m_if.araddr);
      if (m_if.awvalid && m_if.awready) dn_ev(0, 1, m_if.awaddr);
      if (m_if.wvalid && m_if.wready)   dn_ev(0, 2, m_if.wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_read(input logic [31:0] a, input logic [31:0] ed,
                         input logic [1:0] er, input int tgt,
                         input bit push_r);
    int n = 0;
    if (push_r) r_q.push_back('{ed, er});
    if (tgt >= 0) dn_q.push_back('{tgt, 0, a});
    @(posedge clk); #1;
    s_if.araddr  = a;
    s_if.arvalid = 1'b1;
    @(negedge clk);
    while (!s_if.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL ar_timeout: got no arready expected arready for %h", a);
    end
    @(posedge clk); #1;
    s_if.arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int wdly, input logic [1:0] er,
                          input int tgt);
    int  n = 0;
    bit  wdone;
    b_q.push_back(er);
    if (tgt >= 0) begin
      dn_q.push_back('{tgt, 1, a});
      dn_q.push_back('{tgt, 2, d});
    end
    @(posedge clk); #1;
    s_if.awaddr  = a;
    s_if.awvalid = 1'b1;
    if (wdly == 0) begin
      s_if.wdata  = d;
      s_if.wstrb  = 4'hf;
      s_if.wvalid = 1'b1;
    end
    @(negedge clk);
    while (!s_if.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: got no awready expected awready for %h", a);
    end
    wdone = s_if.wvalid && s_if.wready;
    @(posedge clk); #1;
    s_if.awvalid = 1'b0;
    if (wdone) s_if.wvalid = 1'b0;
    if (!wdone) begin
      if (wdly > 0) begin
        repeat (wdly - 1) @(posedge clk);
        #1;
        s_if.wdata  = d;
        s_if.wstrb  = 4'hf;
        s_if.wvalid = 1'b1;
      end
      n = 0;
      @(negedge clk);
      while (!s_if.wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
        n_tests++; n_fail++;
        $display("FAIL w_timeout: got no wready expected wready for %h", a);
      end
      @(posedge clk); #1;
      s_if.wvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0 || dn_q.size() != 0)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [31:0] vlds();
    return {24'd0, c_if.arvalid, c_if.awvalid, c_if.wvalid,
            m_if.arvalid, m_if.awvalid, m_if.wvalid,
            s_if.rvalid, s_if.bvalid};
  endfunction

  initial begin
    int n;
    reset        = 1'b1;
    s_if.rready  = 1'b1;
    s_if.bready  = 1'b1;
    s_if.araddr  = 32'h80000000;
    s_if.arvalid = 1'b1;
    s_if.awaddr  = 32'h0a000000;
    s_if.awvalid = 1'b1;
    s_if.wdata   = 32'h0;
    s_if.wstrb   = 4'h0;
    s_if.wvalid  = 1'b1;

    // upstream valids held high through reset must not leak
    repeat (3) begin
      @(negedge clk);
      chk("rst_valids", vlds(), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_plus1_valids", vlds(), 32'd0);
    @(posedge clk); #1;
    s_if.arvalid = 1'b0;
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;

    // mtime words from the CLINT, back to back
    do_read(32'h0a000048, 32'h3456789a, 2'b00, 1, 1'b1);
    do_read(32'h0a00004c, 32'h00000012, 2'b00, 1, 1'b1);
    drain();

    // memory write with late W, then read it back
    do_write(32'h80000010, 32'hdeadbeef, 2, 2'b00, 0);
    do_read(32'h80000010, 32'hdeadbeef, 2'b00, 0, 1'b1);
    drain();

    // CLINT write with AW and W together
    do_write(32'h0a000048, 32'h00000005, 0, 2'b10, 1);
    drain();

    fork
      do_read(32'h80000000, 32'h80000000, 2'b00, 0, 1'b1);
      do_write(32'h0a000000, 32'h00000001, 0, 2'b00, 1);
    join
    drain();

    // window edges and holes
    do_read(32'h00000000, 32'h0, DEC ? 2'b11 : 2'b00,
            DEC ? -1 : 0, 1'b1);
    do_read(32'h0a00fffc, 32'h0, 2'b00, 1, 1'b1);
    do_read(32'h0a010000, DEC ? 32'h0 : 32'h0a010000,
            DEC ? 2'b11 : 2'b00, DEC ? -1 : 0, 1'b1);
    do_read(32'h09fffffc, DEC ? 32'h0 : 32'h09fffffc,
            DEC ? 2'b11 : 2'b00, DEC ? -1 : 0, 1'b1);
    do_read(32'h87fffffc, 32'h87fffffc, 2'b00, 0, 1'b1);
    do_write(32'h00000100, 32'h12345678, 1,
             DEC ? 2'b11 : 2'b00, DEC ? -1 : 0);
    drain();

    // reset while a read response is pending
    s_if.rready = 1'b0;
    do_read(32'h80000000, 32'h0, 2'b00, 0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!s_if.rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rd_pending", {31'd0, s_if.rvalid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rvalid", {31'd0, s_if.rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_if.rready = 1'b1;
    @(negedge clk);
    chk("rst_mid_plus1", vlds(), 32'd0);
    @(negedge clk);
    chk("post_rst_rvalid", {31'd0, s_if.rvalid}, 32'd0);
    chk("post_rst_idle", {31'd0, s_if.arready}, 32'd1);
    do_read(32'h0a00004c, 32'h00000012, 2'b00, 1, 1'b1);
    drain();

    chk("r_q_left", r_q.size(), 32'd0);
    chk("b_q_left", b_q.size(), 32'd0);
    chk("dn_q_left", dn_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_xbar.md
AXI_LITE_XBAR -- requirements
Module: axi_lite_xbar

Interface
REQ-001 Parameter CLINT_BASE, default 32'h0a000000, meaning base of the CLINT window.
REQ-002 Parameter CLINT_SIZE, default 32'h00010000, meaning byte size of the CLINT window.
REQ-003 Parameter MEM_BASE, default 32'h80000000, meaning base of the memory window.
REQ-004 Parameter MEM_SIZE, default 32'h08000000, meaning byte size of the memory window.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s  axi_lite_if.slave  bundle  upstream port from the core's LSU/IFU arbiter.
REQ-008 m_clint  axi_lite_if.master  bundle  downstream port to clint.
REQ-009 m_mem  axi_lite_if.master  bundle  downstream port to memory/peripheral fabric.

Function
REQ-010 Decode SHALL be: CLINT if CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE; else MEM; compares are 32-bit unsigned, no wrap.
REQ-011 Read FSM SHALL have states RD_IDLE, RD_WAIT, RD_ERR; write FSM SHALL have WR_IDLE, WR_DATA, WR_RESP, WR_ERR; the two FSMs are independent.
REQ-012 RD_IDLE: araddr SHALL pass combinationally to both masters; arvalid asserted only on the decoded target; s.arready SHALL equal the decoded target's arready.
REQ-013 On s AR handshake the target select SHALL be registered and the FSM SHALL enter RD_WAIT; s.arready SHALL be 0 outside RD_IDLE (one outstanding read).
REQ-014 RD_WAIT: rvalid/rdata/rresp SHALL be muxed from the registered target, rready routed only to it; on R handshake return to RD_IDLE; back-to-back ARs SHALL incur no bubble beyond that cycle.
REQ-015 WR_IDLE: awaddr/wdata/wstrb SHALL pass to both masters; awvalid and wvalid SHALL be forwarded only to the target decoded from awaddr; s.wready SHALL be 0 while s.awvalid is 0 (W never precedes AW).
REQ-016 On AW handshake: if W handshakes in the same cycle go to WR_RESP, else go to WR_DATA with target registered.
REQ-017 WR_DATA: wvalid/wready SHALL connect to the registered target only; on W handshake go to WR_RESP.
REQ-018 WR_RESP: bvalid/bresp SHALL be muxed from the registered target, bready routed only to it; on B handshake go to WR_IDLE.
REQ-019 Unselected master ports SHALL see arvalid, awvalid, wvalid, rready and bready all 0.
REQ-020 Simultaneous read and write SHALL proceed concurrently, including to the same target.
REQ-021 Without XBAR_DECERR_EN, RD_ERR and WR_ERR SHALL be unreachable.

Reset
REQ-022 Reset SHALL force RD_IDLE, WR_IDLE, registered selects to MEM.
REQ-023 During and one cycle after reset, all valid outputs on m_clint/m_mem and s.rvalid/s.bvalid SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon it; no response SHALL be issued for it afterward.

Configuration
REQ-025 Macro XBAR_DECERR_EN: when defined, addresses in neither window SHALL be decoded ERR and answered locally.
REQ-026 With XBAR_DECERR_EN: ERR read SHALL be accepted (arready=1 in RD_IDLE), enter RD_ERR, drive rvalid=1, rdata=0, rresp=2'b11 until R handshake, no downstream arvalid.
REQ-027 With XBAR_DECERR_EN: ERR write SHALL accept AW and W locally (via WR_DATA if W late), enter WR_ERR, drive bvalid=1, bresp=2'b11 until B handshake, no downstream valid.
REQ-028 Without XBAR_DECERR_EN: every non-CLINT address SHALL route to m_mem.

Verification
REQ-029 Read 0x0a000048 then 0x0a00004c -> routed to m_clint, rdata equals successive mtime words, m_mem arvalid stays 0.
REQ-030 Write 0x80000010 data 0xdeadbeef with W two cycles after AW -> m_mem sees AW then W, s.bresp 2'b00; m_clint untouched.
REQ-031 Write 0x0a000048 with AW and W in same cycle -> WR_IDLE to WR_RESP directly, s.bresp 2'b10 from clint.
REQ-032 Concurrent read 0x80000000 and write 0x0a000000 -> both complete independently, responses correctly steered.
REQ-033 Read 0x00000000 -> with XBAR_DECERR_EN rresp 2'b11, rdata 0, no downstream arvalid; without, routed to m_mem.
REQ-034 Assert reset in RD_WAIT with rvalid pending -> s.rvalid 0 after reset, FSM in RD_IDLE, next read served normally.
